// File: rtl/alu_muldiv_seq_if.sv
// Handshake bundle for alu_muldiv_seq: operation request channel and registered result channel.
interface alu_muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            branch_taken;
    logic            div_by_zero;
    logic            busy;

    modport master (
        output in_valid, op, funct3, src1, src2, out_ready,
        input  in_ready, out_valid, result, branch_taken, div_by_zero, busy
    );

    modport slave (
        input  in_valid, op, funct3, src1, src2, out_ready,
        output in_ready, out_valid, result, branch_taken, div_by_zero, busy
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Registered RV32I/M execute unit: 1-cycle base ALU and branch compare, iterative multiply/divide.
// Define ALU_DIV_EN to compile in the restoring divider; otherwise ops 14-17 return 0 in one cycle.
module alu_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    alu_muldiv_seq_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SLT = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
    localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9,  OP_MUL = 5'd10, OP_MULHU = 5'd13;
`ifdef ALU_DIV_EN
    localparam logic [4:0] OP_DIV = 5'd14, OP_DIVU = 5'd15, OP_REM = 5'd16, OP_REMU = 5'd17;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL} state_t;
`endif

    function automatic logic [XLEN-1:0] alu_base(input logic [4:0] op,
                                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa, sb;
        logic [SHW-1:0]         sh;
        sa = a;
        sb = b;
        sh = b[SHW-1:0];
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLL:  return a << sh;
            OP_SLT:  return {{(XLEN-1){1'b0}}, sa < sb};
            OP_SLTU: return {{(XLEN-1){1'b0}}, a < b};
            OP_XOR:  return a ^ b;
            OP_SRL:  return a >> sh;
            OP_SRA:  return $unsigned(sa >>> sh);
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            default: return '0;
        endcase
    endfunction

    function automatic logic br_eval(input logic [2:0] f3,
                                     input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return sa < sb;
            3'b101:  return sa >= sb;
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              branch_q, branch_d;
    logic              dbz_q, dbz_d;
    logic [4:0]        op_q, op_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d, acc_q, acc_d, acc_n;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic              in_ready, accept, is_mul, last_iter;
`ifdef ALU_DIV_EN
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? -v : v;
    endfunction

    logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
    logic              negq_q, negq_d, negr_q, negr_d;
    logic [XLEN:0]     r_sh;
    logic [XLEN-1:0]   rem_n, quo_n;
    logic              ge, is_div, signed_div;

    assign is_div     = (bus.op >= OP_DIV) && (bus.op <= OP_REMU);
    assign signed_div = (bus.op == OP_DIV) || (bus.op == OP_REM);
`endif

    assign in_ready  = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign is_mul    = (bus.op >= OP_MUL) && (bus.op <= OP_MULHU);
    assign last_iter = (cnt_q == SHW'(XLEN-1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        branch_d    = branch_q;
        dbz_d       = dbz_q;
        op_d        = op_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        acc_n       = acc_q;
`ifdef ALU_DIV_EN
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvsr_d = dvsr_q;
        negq_d = negq_q;
        negr_d = negr_q;
        r_sh   = {rem_q, quo_q[XLEN-1]};
        ge     = r_sh >= {1'b0, dvsr_q};
        rem_n  = ge ? (r_sh[XLEN-1:0] - dvsr_q) : r_sh[XLEN-1:0];
        quo_n  = {quo_q[XLEN-2:0], ge};
`endif
        if (out_valid_q && bus.out_ready)
            out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d     = bus.op;
                    branch_d = 1'b0;
                    dbz_d    = 1'b0;
                    if (is_mul) begin
                        state_d  = MUL;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mplier_d = bus.src2;
                        mcand_d  = (bus.op == OP_MULHU) ? {{XLEN{1'b0}}, bus.src1}
                                                        : {{XLEN{bus.src1[XLEN-1]}}, bus.src1};
                    end
`ifdef ALU_DIV_EN
                    else if (is_div) begin
                        if (bus.src2 == '0) begin
                            result_d    = (bus.op == OP_DIV || bus.op == OP_DIVU) ? '1 : bus.src1;
                            dbz_d       = 1'b1;
                            out_valid_d = 1'b1;
                        end else if (signed_div && bus.src2 == '1 &&
                                     bus.src1 == {1'b1, {(XLEN-1){1'b0}}}) begin
                            result_d    = (bus.op == OP_DIV) ? bus.src1 : '0;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d = DIV;
                            cnt_d   = '0;
                            rem_d   = '0;
                            quo_d   = signed_div ? mag(bus.src1) : bus.src1;
                            dvsr_d  = signed_div ? mag(bus.src2) : bus.src2;
                            negq_d  = (bus.op == OP_DIV) && (bus.src1[XLEN-1] ^ bus.src2[XLEN-1]);
                            negr_d  = (bus.op == OP_REM) && bus.src1[XLEN-1];
                        end
                    end
`endif
                    else begin
                        result_d    = alu_base(bus.op, bus.src1, bus.src2);
                        branch_d    = (bus.op <= OP_AND) ? br_eval(bus.funct3, bus.src1, bus.src2) : 1'b0;
                        out_valid_d = 1'b1;
                    end
                end
            end
            MUL: begin
                // MULH treats the multiplier MSB as weight -2^(XLEN-1): subtract on the final step.
                if (mplier_q[0])
                    acc_n = (last_iter && op_q == 5'd11) ? acc_q - mcand_q : acc_q + mcand_q;
                acc_d    = acc_n;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (last_iter) begin
                    result_d    = (op_q == OP_MUL) ? acc_n[XLEN-1:0] : acc_n[2*XLEN-1:XLEN];
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
`ifdef ALU_DIV_EN
            DIV: begin
                rem_d = rem_n;
                quo_d = quo_n;
                cnt_d = cnt_q + SHW'(1);
                if (last_iter) begin
                    if (op_q == OP_DIV || op_q == OP_DIVU)
                        result_d = negq_q ? -quo_n : quo_n;
                    else
                        result_d = negr_q ? -rem_n : rem_n;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            branch_q    <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            branch_q    <= branch_d;
            dbz_q       <= dbz_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q     <= op_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        acc_q    <= acc_d;
`ifdef ALU_DIV_EN
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        dvsr_q <= dvsr_d;
        negq_q <= negq_d;
        negr_q <= negr_d;
`endif
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.result       = result_q;
    assign bus.branch_taken = branch_q;
    assign bus.div_by_zero  = dbz_q;
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: base ops, branches, MUL/DIV latency, special divides, stall, reset abort.
module tb_alu_muldiv_seq;
`ifdef ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    alu_muldiv_seq_if #(.XLEN(32)) bus ();
    alu_muldiv_seq #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic run_op(input logic [4:0] o, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] r, output logic br,
                          output logic dz, output int lat);
        bus.op       = o;
        bus.funct3   = f;
        bus.src1     = a;
        bus.src2     = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        r  = bus.result;
        br = bus.branch_taken;
        dz = bus.div_by_zero;
    endtask

    logic [31:0] r, keep_r;
    logic        br, dz, keep_br, keep_dz, ok;
    int          lat, cnt;

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.op = '0; bus.funct3 = 3'b010; bus.src1 = '0; bus.src2 = '0;
        tick(); tick();
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        rst = 1'b0;

        // ADD then back-to-back SRA
        bus.op = 5'd0; bus.src1 = 32'd7; bus.src2 = 32'hFFFF_FFFD; bus.in_valid = 1'b1;
        tick();
        chk("add_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("add_result", bus.result, 32'd4);
        bus.op = 5'd7; bus.src1 = 32'h8000_0000; bus.src2 = 32'd4;
        tick();
        chk("sra_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("sra_result", bus.result, 32'hF800_0000);
        bus.in_valid = 1'b0;
        tick();
        chk("idle_valid", {31'd0, bus.out_valid}, 32'd0);

        // Branch compares
        run_op(5'd3, 3'b100, 32'hFFFF_FFFF, 32'd1, r, br, dz, lat);
        chk("blt_taken", {31'd0, br}, 32'd1);
        chk("slt_result", r, 32'd1);
        run_op(5'd4, 3'b110, 32'hFFFF_FFFF, 32'd1, r, br, dz, lat);
        chk("bltu_taken", {31'd0, br}, 32'd0);
        chk("sltu_result", r, 32'd0);
        run_op(5'd0, 3'b101, 32'd1, 32'hFFFF_FFFF, r, br, dz, lat);
        chk("bge_taken", {31'd0, br}, 32'd1);
        run_op(5'd0, 3'b000, 32'd9, 32'd9, r, br, dz, lat);
        chk("beq_taken", {31'd0, br}, 32'd1);
        run_op(5'd20, 3'b000, 32'd9, 32'd9, r, br, dz, lat);
        chk("unk_result", r, 32'd0);
        chk("unk_latency", lat, 32'd1);

        // MULH with a queued ADD whose operands must not disturb the running multiply
        bus.op = 5'd11; bus.src1 = 32'h8000_0000; bus.src2 = 32'h8000_0000; bus.in_valid = 1'b1;
        tick();
        bus.op = 5'd0; bus.src1 = 32'd5; bus.src2 = 32'd6; bus.funct3 = 3'b010;
        cnt = 0;
        repeat (32) begin
            if (bus.busy && !bus.in_ready && !bus.out_valid) cnt++;
            tick();
        end
        chk("mulh_busy_cycles", cnt, 32'd32);
        chk("mulh_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("mulh_result", bus.result, 32'h4000_0000);
        chk("mulh_busy_done", {31'd0, bus.busy}, 32'd0);
        tick();
        chk("queued_add", bus.result, 32'd11);
        bus.in_valid = 1'b0;
        tick();

        run_op(5'd10, 3'b000, 32'hFFFF_FFFF, 32'd3, r, br, dz, lat);
        chk("mul_result", r, 32'hFFFF_FFFD);
        chk("mul_latency", lat, 32'd33);
        chk("mul_branch", {31'd0, br}, 32'd0);
        run_op(5'd13, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, br, dz, lat);
        chk("mulhu_result", r, 32'hFFFF_FFFE);
        run_op(5'd12, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, br, dz, lat);
        chk("mulhsu_result", r, 32'hFFFF_FFFF);

        // Divide family
        run_op(5'd15, 3'b000, 32'd100, 32'd7, r, br, dz, lat);
        chk("divu_result", r, DIV_EN ? 32'd14 : 32'd0);
        chk("divu_latency", lat, DIV_EN ? 32'd33 : 32'd1);
        run_op(5'd16, 3'b000, 32'hFFFF_FFF9, 32'd2, r, br, dz, lat);
        chk("rem_result", r, DIV_EN ? 32'hFFFF_FFFF : 32'd0);
        run_op(5'd14, 3'b000, 32'hFFFF_FFF9, 32'd2, r, br, dz, lat);
        chk("div_neg_result", r, DIV_EN ? 32'hFFFF_FFFD : 32'd0);
        run_op(5'd14, 3'b000, 32'h8000_0000, 32'hFFFF_FFFF, r, br, dz, lat);
        chk("div_ovf_result", r, DIV_EN ? 32'h8000_0000 : 32'd0);
        chk("div_ovf_latency", lat, 32'd1);
        chk("div_ovf_dbz", {31'd0, dz}, 32'd0);
        run_op(5'd14, 3'b000, 32'd5, 32'd0, r, br, dz, lat);
        chk("div0_result", r, DIV_EN ? 32'hFFFF_FFFF : 32'd0);
        chk("div0_dbz", {31'd0, dz}, DIV_EN ? 32'd1 : 32'd0);
        chk("div0_latency", lat, 32'd1);
        run_op(5'd17, 3'b000, 32'd5, 32'd0, r, br, dz, lat);
        chk("remu0_result", r, DIV_EN ? 32'd5 : 32'd0);
        tick();

        // Output stall with a pending request held by the source
        bus.out_ready = 1'b0;
        bus.op = 5'd0; bus.funct3 = 3'b001; bus.src1 = 32'd2; bus.src2 = 32'd3; bus.in_valid = 1'b1;
        tick();
        keep_r = bus.result; keep_br = bus.branch_taken; keep_dz = bus.div_by_zero;
        chk("stall_first", keep_r, 32'd5);
        chk("stall_branch", {31'd0, keep_br}, 32'd1);
        bus.op = 5'd1; bus.src1 = 32'd9; bus.src2 = 32'd1;
        ok = 1'b1;
        repeat (3) begin
            tick();
            if (!bus.out_valid || bus.in_ready || bus.result !== keep_r ||
                bus.branch_taken !== keep_br || bus.div_by_zero !== keep_dz) ok = 1'b0;
        end
        chk("stall_stable", {31'd0, ok}, 32'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("stall_release", bus.result, 32'd8);
        bus.in_valid = 1'b0;
        tick();
        chk("stall_drain", {31'd0, bus.out_valid}, 32'd0);

        // Reset during multiply iteration 10
        bus.op = 5'd10; bus.src1 = 32'd3; bus.src2 = 32'd4; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        ok = 1'b0;
        repeat (40) begin
            if (bus.out_valid) ok = 1'b1;
            tick();
        end
        chk("abort_no_valid", {31'd0, ok}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
